sub_bytes_sched: RTL and testbench

Time-shared S-box scheduler for the AES core. Four S-box lanes (32 bits, one word per cycle) serve two requesters: the round datapath's 128-bit SubBytes state job and the key expansion's 32-bit SubWord job. The block queues one job per requester, grants lanes cycle by cycle, and returns substituted results. It sits between the round controller, the key expander and the four shared `sbox` instances it owns.

---
 rtl/sub_bytes_sched.sv | 189 ++++++++++++++++++
 tb/tb_sub_bytes_sched.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_sched.sv
// Time-shared AES S-box scheduler: four byte lanes serve a 128-bit state job and a 32-bit key word.
// Optional macro SBOX_OUT_REG_EN registers the lane results (+1 cycle latency, same issue schedule).

module sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 as AES requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  assign y_o = affine(ginv(a_i));
endmodule

module sub_bytes_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic [127:0] st_in,
  output logic         st_out_valid,
  output logic [127:0] st_out,
  input  logic         kw_valid,
  output logic         kw_ready,
  input  logic [31:0]  kw_in,
  output logic         kw_out_valid,
  output logic [31:0]  kw_out
);
  localparam int NUM_LANES = 4;

  typedef enum logic {ST_IDLE, ST_BUSY} st_e;

  st_e                  st_q;
  logic [1:0]           wc_q;
  logic [1:0]           wc_d;
  logic                 drain_q;
  logic [3:0][31:0]     st_buf_q;
  logic [3:0][31:0]     st_out_q;
  logic                 st_out_valid_q;
  logic                 kp_q;
  logic [31:0]          kw_buf_q;
  logic [31:0]          kw_out_q;
  logic                 kw_out_valid_q;

  logic st_acc, kw_acc, key_go, st_go;
  logic [NUM_LANES-1:0][7:0] lane_in, lane_out;

  assign st_ready = !rst && (st_q == ST_IDLE);
  assign kw_ready = !rst && !kp_q;
  assign st_acc   = st_valid && st_ready;
  assign kw_acc   = kw_valid && kw_ready;

  // A pending key always wins; the state job simply holds its word counter.
  assign key_go  = kp_q;
  assign st_go   = !kp_q && (st_q == ST_BUSY) && !drain_q;
  assign wc_d    = wc_q + 2'd1;
  assign lane_in = key_go ? kw_buf_q : st_buf_q[wc_q];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    sbox u_sbox (
      .a_i (lane_in[g]),
      .y_o (lane_out[g])
    );
  end

  logic        wr_vld, wr_key;
  logic [1:0]  wr_wc;
  logic [31:0] wr_data;

`ifdef SBOX_OUT_REG_EN
  logic        p_vld_q, p_key_q;
  logic [1:0]  p_wc_q;
  logic [31:0] p_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_vld_q  <= 1'b0;
      p_key_q  <= 1'b0;
      p_wc_q   <= 2'd0;
      p_data_q <= 32'd0;
    end else begin
      p_vld_q  <= key_go || st_go;
      p_key_q  <= key_go;
      p_wc_q   <= wc_q;
      p_data_q <= lane_out;
    end
  end

  assign wr_vld  = p_vld_q;
  assign wr_key  = p_key_q;
  assign wr_wc   = p_wc_q;
  assign wr_data = p_data_q;
`else
  assign wr_vld  = key_go || st_go;
  assign wr_key  = key_go;
  assign wr_wc   = wc_q;
  assign wr_data = lane_out;
`endif

  logic wr_st, wr_kw;
  assign wr_st = wr_vld && !wr_key;
  assign wr_kw = wr_vld && wr_key;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q           <= ST_IDLE;
      wc_q           <= 2'd0;
      drain_q        <= 1'b0;
      st_buf_q       <= '0;
      st_out_q       <= '0;
      st_out_valid_q <= 1'b0;
      kp_q           <= 1'b0;
      kw_buf_q       <= 32'd0;
      kw_out_q       <= 32'd0;
      kw_out_valid_q <= 1'b0;
    end else begin
      st_out_valid_q <= 1'b0;
      kw_out_valid_q <= 1'b0;
      case (st_q)
        ST_IDLE: begin
          if (st_acc) begin
            st_buf_q <= st_in;
            wc_q     <= 2'd0;
            drain_q  <= 1'b0;
            st_q     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // drain_q marks "all words issued, waiting on the last write".
          if (st_go) begin
            wc_q <= wc_d;
            if (wc_q == 2'd3) drain_q <= 1'b1;
          end
          if (wr_st) begin
            st_out_q[wr_wc] <= wr_data;
            if (wr_wc == 2'd3) begin
              st_q           <= ST_IDLE;
              drain_q        <= 1'b0;
              st_out_valid_q <= 1'b1;
            end
          end
        end
        default: st_q <= ST_IDLE;
      endcase

      if (kw_acc) begin
        kp_q     <= 1'b1;
        kw_buf_q <= kw_in;
      end else if (key_go) begin
        kp_q <= 1'b0;
      end

      if (wr_kw) begin
        kw_out_q       <= wr_data;
        kw_out_valid_q <= 1'b1;
      end
    end
  end

  assign st_out       = st_out_q;
  assign st_out_valid = st_out_valid_q;
  assign kw_out       = kw_out_q;
  assign kw_out_valid = kw_out_valid_q;
endmodule

// File: tb/tb_sub_bytes_sched.sv
// Bench for sub_bytes_sched: vector table plus hand sequences, results checked through scoreboard queues.
module tb_sub_bytes_sched;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         st_valid = 1'b0;
  logic         st_ready;
  logic [127:0] st_in = '0;
  logic         st_out_valid;
  logic [127:0] st_out;
  logic         kw_valid = 1'b0;
  logic         kw_ready;
  logic [31:0]  kw_in = '0;
  logic         kw_out_valid;
  logic [31:0]  kw_out;

`ifdef SBOX_OUT_REG_EN
  localparam int XL = 1;
`else
  localparam int XL = 0;
`endif

  localparam logic [127:0] SPEC_ST     = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] SPEC_ST_EXP = 128'h76abd7fe2b670130c56f6bf27b777c63;
  localparam logic [31:0]  SPEC_KW     = 32'h55545352;
  localparam logic [31:0]  SPEC_KW_EXP = 32'hfc20ed00;

  sub_bytes_sched dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_in(st_in),
    .st_out_valid(st_out_valid), .st_out(st_out),
    .kw_valid(kw_valid), .kw_ready(kw_ready), .kw_in(kw_in),
    .kw_out_valid(kw_out_valid), .kw_out(kw_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] sbox_tab [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox_tab[w[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] sub_state(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = sub_word(s[32*i +: 32]);
    return r;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { logic [127:0] d; int at; } exp_t;
  exp_t st_q[$];
  exp_t kw_q[$];

  // Output monitor: every pulse must match the oldest expectation in data and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (st_out_valid) begin
      chk("st_ready_in_pulse", st_ready, 1'b1);
      if (st_q.size() == 0) chk("st_unexpected_pulse", st_out_valid, 1'b0);
      else begin
        e = st_q.pop_front();
        chk("st_data", st_out, e.d);
        chk("st_cycle", cyc, e.at);
      end
    end
    if (kw_out_valid) begin
      if (kw_q.size() == 0) chk("kw_unexpected_pulse", kw_out_valid, 1'b0);
      else begin
        e = kw_q.pop_front();
        chk("kw_data", {96'd0, kw_out}, e.d);
        chk("kw_cycle", cyc, e.at);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(st_ready && kw_ready && st_q.size() == 0 && kw_q.size() == 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("idle_timeout", n, 0);
  endtask

  typedef struct {
    logic [127:0] st;
    logic [31:0]  kw;
    int           kd;
    logic [127:0] exp_st;
    logic [31:0]  exp_kw;
  } vec_t;

  vec_t vt[6];

  initial begin
    int c;
    int pulses;
    logic [127:0] rs;

    vt[0] = '{SPEC_ST, 32'h0, -1, SPEC_ST_EXP, 32'h0};
    vt[1] = '{SPEC_ST, SPEC_KW, 1, SPEC_ST_EXP, SPEC_KW_EXP};
    vt[2] = '{SPEC_ST, SPEC_KW, 0, SPEC_ST_EXP, SPEC_KW_EXP};
    vt[3].st = {$urandom, $urandom, $urandom, $urandom};
    vt[3].kw = $urandom;
    vt[3].kd = 2;
    vt[3].exp_st = sub_state(vt[3].st);
    vt[3].exp_kw = sub_word(vt[3].kw);
    vt[4] = '{{128{1'b1}}, 32'h0, 3, {16{8'h16}}, 32'h63636363};
    vt[5].st = {$urandom, $urandom, $urandom, $urandom};
    vt[5].kw = 32'h0;
    vt[5].kd = -1;
    vt[5].exp_st = sub_state(vt[5].st);
    vt[5].exp_kw = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_st_ready", st_ready, 1'b0);
    chk("rst_kw_ready", kw_ready, 1'b0);
    chk("rst_st_out_valid", st_out_valid, 1'b0);
    chk("rst_kw_out_valid", kw_out_valid, 1'b0);
    chk("rst_st_out", st_out, 128'd0);
    chk("rst_kw_out", {96'd0, kw_out}, 128'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_st_ready", st_ready, 1'b1);
    chk("post_rst_kw_ready", kw_ready, 1'b1);

    // Vector table: state job with an optional key offered kd cycles later
    foreach (vt[i]) begin
      wait_idle();
      c = cyc;
      st_valid = 1'b1;
      st_in = vt[i].st;
      chk("vec_st_ready", st_ready, 1'b1);
      st_q.push_back('{vt[i].exp_st, c + 5 + XL + ((vt[i].kd >= 0) ? 1 : 0)});
      if (vt[i].kd == 0) begin
        kw_valid = 1'b1;
        kw_in = vt[i].kw;
        kw_q.push_back('{{96'd0, vt[i].exp_kw}, c + 2 + XL});
      end
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        st_valid = 1'b0;
        kw_valid = 1'b0;
        if (k == 1) chk("vec_st_busy", st_ready, 1'b0);
        if (vt[i].kd == k - 1) chk("vec_kw_busy", kw_ready, 1'b0);
        if (vt[i].kd == k && k <= 3) begin
          kw_valid = 1'b1;
          kw_in = vt[i].kw;
          kw_q.push_back('{{96'd0, vt[i].exp_kw}, cyc + 2 + XL});
        end
      end
    end

    // kw_valid held high through a state job: keys every 2 cycles, state done at T+9
    wait_idle();
    c = cyc;
    rs = {$urandom, $urandom, $urandom, $urandom};
    st_valid = 1'b1;
    st_in = rs;
    st_q.push_back('{sub_state(rs), c + 9 + XL});
    kw_valid = 1'b1;
    for (int j = 0; j < 10; j++) begin
      kw_in = $urandom;
      if (kw_ready) kw_q.push_back('{{96'd0, sub_word(kw_in)}, cyc + 2 + XL});
      if (j == 4) chk("hold_st_busy", st_ready, 1'b0);
      @(negedge clk);
      st_valid = 1'b0;
    end
    kw_valid = 1'b0;

    // Reset two cycles into a state job drops it without a pulse
    wait_idle();
    st_valid = 1'b1;
    st_in = SPEC_ST;
    @(negedge clk);
    st_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_st_ready", st_ready, 1'b0);
    chk("mid_rst_kw_ready", kw_ready, 1'b0);
    chk("mid_rst_st_out", st_out, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_release_ready", st_ready, 1'b1);
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (st_out_valid) pulses++;
    end
    chk("mid_rst_no_pulse", pulses, 0);
    chk("mid_rst_st_out_zero", st_out, 128'd0);
    chk("mid_rst_kw_out_zero", {96'd0, kw_out}, 128'd0);
    c = cyc;
    st_valid = 1'b1;
    st_in = SPEC_ST;
    st_q.push_back('{SPEC_ST_EXP, c + 5 + XL});
    @(negedge clk);
    st_valid = 1'b0;

    wait_idle();
    chk("st_queue_drained", st_q.size(), 0);
    chk("kw_queue_drained", kw_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
